// File: rtl/gate_bist_pkg.sv
// Shared types, default constants and the Galois step helper for the gate-model BIST.
package gate_bist_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSettle,
        StCapture,
        StCmp,
        StDone
    } bist_state_e;

    // Defaults for the 17-input / 10-output gate models.
    localparam int unsigned       DefInW      = 17;
    localparam int unsigned       DefOutW     = 10;
    localparam logic [16:0]       DefLfsrSeed = 17'h00001;
    localparam logic [16:0]       DefLfsrPoly = 17'h00009;  // x^17 + x^3 + 1
    localparam logic [9:0]        DefMisrSeed = 10'h000;
    localparam logic [9:0]        DefMisrPoly = 10'h009;    // x^10 + x^3 + 1

    // Widest register the helper below can step.
    localparam int unsigned MaxW = 32;

    // One Galois step of a width-bit register: shift left, fold the mask in when the MSB falls out.
    function automatic logic [MaxW-1:0] lfsr_next(input logic [MaxW-1:0] value,
                                                  input logic [MaxW-1:0] poly,
                                                  input int unsigned     width);
        logic [MaxW-1:0] mask;
        logic [MaxW-1:0] shifted;
        mask    = (width >= MaxW) ? '1 : ((MaxW'(1) << width) - MaxW'(1));
        shifted = (value << 1) & mask;
        if (value[width-1]) begin
            shifted = shifted ^ (poly & mask);
        end
        return shifted;
    endfunction

endpackage

// File: rtl/gate_bist_lfsr.sv
// Generic Galois shift register with load and enable; data_i is XORed into each step,
// so it serves both as the pattern LFSR (data tied 0) and as the MISR.
module gate_bist_lfsr
    import gate_bist_pkg::*;
#(
    parameter int unsigned      Width = 17,
    parameter logic [Width-1:0] Poly  = '0,
    parameter logic [Width-1:0] Seed  = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [Width-1:0] data_i,
    output logic [Width-1:0] value_o
);

    logic [Width-1:0] value_q;
    logic [Width-1:0] value_d;
    logic [Width-1:0] stepped;

    // Next value: load wins over step, otherwise hold.
    always_comb begin
        stepped = Width'(lfsr_next(MaxW'(value_q), MaxW'(Poly), Width));
        value_d = value_q;
        if (load_i) begin
            value_d = Seed;
        end else if (en_i) begin
            value_d = stepped ^ data_i;
        end
    end

    // Register with synchronous reset to the seed.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            value_q <= Seed;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/gate_bist_controller.sv
// BIST driver for a combinational gate model: LFSR patterns out, MISR-compacted responses in,
// signature compared against a golden value after N_PAT patterns.
module gate_bist_controller
    import gate_bist_pkg::*;
#(
    parameter int unsigned      IN_W      = DefInW,
    parameter int unsigned      OUT_W     = DefOutW,
    parameter int unsigned      N_PAT     = 256,
    parameter int unsigned      SETTLE    = 1,
    parameter logic [IN_W-1:0]  LFSR_SEED = DefLfsrSeed,
    parameter logic [IN_W-1:0]  LFSR_POLY = DefLfsrPoly,
    parameter logic [OUT_W-1:0] MISR_SEED = DefMisrSeed,
    parameter logic [OUT_W-1:0] MISR_POLY = DefMisrPoly,
    localparam int unsigned     CntW      = $clog2(N_PAT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [OUT_W-1:0] expected_sig,
    input  logic [OUT_W-1:0] response_in,
    output logic [IN_W-1:0]  pattern_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [OUT_W-1:0] signature,
    output logic [CntW-1:0]  pat_cnt
);

    localparam int unsigned       SetW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SetW-1:0]   SettleLoad = SetW'(SETTLE - 1);
    localparam logic [CntW-1:0]   LastCnt    = CntW'(N_PAT - 1);

    bist_state_e     state_q, state_d;
    logic [SetW-1:0] settle_q, settle_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic            lfsr_load, lfsr_en;
    logic            misr_load, misr_en;

    // Next-state, counter and register-strobe decode.
    always_comb begin
        state_d   = state_q;
        settle_d  = settle_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = done_q;
        pass_d    = pass_q;
        lfsr_load = 1'b0;
        lfsr_en   = 1'b0;
        misr_load = 1'b0;
        misr_en   = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d   = StSettle;
                    settle_d  = SettleLoad;
                    cnt_d     = '0;
                    lfsr_load = 1'b1;
                    misr_load = 1'b1;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                end
            end
            StSettle: begin
                if (settle_q == '0) begin
                    state_d = StCapture;
                end else begin
                    settle_d = settle_q - SetW'(1);
                end
            end
            StCapture: begin
                misr_en = 1'b1;
                cnt_d   = cnt_q + CntW'(1);
                // Last pattern stays on the bus through CMP/DONE.
                if (cnt_q == LastCnt) begin
                    state_d = StCmp;
                end else begin
                    lfsr_en  = 1'b1;
                    settle_d = SettleLoad;
                    state_d  = StSettle;
                end
            end
            StCmp: begin
                pass_d  = (signature == expected_sig);
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM state and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            settle_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
        end
    end

    gate_bist_lfsr #(
        .Width (IN_W),
        .Poly  (LFSR_POLY),
        .Seed  (LFSR_SEED)
    ) u_pattern_lfsr (
        .clk_i   (clk),
        .rst_i   (rst),
        .load_i  (lfsr_load),
        .en_i    (lfsr_en),
        .data_i  ('0),
        .value_o (pattern_out)
    );

    gate_bist_lfsr #(
        .Width (OUT_W),
        .Poly  (MISR_POLY),
        .Seed  (MISR_SEED)
    ) u_misr (
        .clk_i   (clk),
        .rst_i   (rst),
        .load_i  (misr_load),
        .en_i    (misr_en),
        .data_i  (response_in),
        .value_o (signature)
    );

    assign busy    = busy_q;
    assign done    = done_q;
    assign pass    = pass_q;
    assign pat_cnt = cnt_q;

    // An all-zero pattern register would lock up; only a zero seed can get it there.
    a_lfsr_nonzero: assert property (@(posedge clk) disable iff (rst) pattern_out != '0);

endmodule
